// File: rtl/neander_io_pkg.sv
// Shared constants for the NEANDER-X byte I/O controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package neander_io_pkg;

  // Bit positions inside the io_status byte
  localparam int ST_RX_NE   = 0;
  localparam int ST_TX_BUSY = 1;
  localparam int ST_RX_FULL = 2;
  localparam int ST_RX_OVF  = 3;
  localparam int ST_TX_OVF  = 4;

  // IN/OUT port addresses seen by the datapath
  localparam logic [7:0] IO_PORT_DATA   = 8'h00;
  localparam logic [7:0] IO_PORT_STATUS = 8'h01;

  // Default receive FIFO depth (power of two, at least 2)
  localparam int RX_DEPTH_DFLT = 4;

  // Outbound holding register occupancy
  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/io_rx_fifo.sv
// Show-ahead receive FIFO: head byte is valid combinationally whenever not empty.
// Latency: a byte pushed at edge N is on head after edge N; pop advances head at the edge.
// Backpressure: push is ignored when full, pop is ignored when empty.
module io_rx_fifo
  import neander_io_pkg::*;
#(
  parameter int DEPTH = RX_DEPTH_DFLT,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage array; contents are meaningless while empty, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/neander_io_ctrl.sv
// Byte I/O controller for the NEANDER-X OUT/IN instructions: one-entry TX holding register plus RX FIFO.
// Latency: io_write shows on tx_valid after one edge; an accepted rx byte shows on io_in after one edge.
// Backpressure: rx_ready = FIFO not full; a write while TX is held and not accepted is dropped.
// Optional sticky overflow status bits are enabled with `define NEANDER_IO_OVF_EN.
module neander_io_ctrl
  import neander_io_pkg::*;
#(
  parameter int RX_DEPTH = RX_DEPTH_DFLT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_write,
  input  logic [7:0] io_out,
  input  logic       io_rd,
  output logic [7:0] io_in,
  output logic [7:0] io_status,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready
);

  localparam int CW = $clog2(RX_DEPTH) + 1;

  tx_state_e     tx_state;
  tx_state_e     tx_state_nxt;
  logic [7:0]    tx_data_q;
  logic          tx_load;
  logic          tx_drop;

  logic          rx_full;
  logic          rx_empty;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count_unused;
  logic          rx_ovf;
  logic          tx_ovf;

  io_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .W     (8)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (io_rd),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count_unused)
  );

  assign rx_ready = ~rx_full;
  assign io_in    = rx_empty ? 8'h00 : rx_head;
  assign tx_valid = (tx_state == TX_FULL);
  assign tx_data  = tx_data_q;

  // TX occupancy register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= TX_EMPTY;
    else       tx_state <= tx_state_nxt;
  end

  // TX next state: a handshake frees the slot, so a same-cycle write refills it instead of dropping
  always_comb begin
    tx_state_nxt = tx_state;
    tx_load      = 1'b0;
    tx_drop      = 1'b0;
    case (tx_state)
      TX_EMPTY: begin
        if (io_write) begin
          tx_load      = 1'b1;
          tx_state_nxt = TX_FULL;
        end
      end
      TX_FULL: begin
        if (tx_ready) begin
          if (io_write) tx_load = 1'b1;
          else          tx_state_nxt = TX_EMPTY;
        end else if (io_write) begin
          tx_drop = 1'b1;
        end
      end
      default: tx_state_nxt = TX_EMPTY;
    endcase
  end

  // Holding register data, only touched on an accepted write so it is stable while offered
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        tx_data_q <= 8'h00;
    else if (tx_load) tx_data_q <= io_out;
  end

`ifdef NEANDER_IO_OVF_EN
  // Sticky overflow flags cleared by a datapath read; a new event in the clearing cycle wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      if (rx_valid & rx_full) rx_ovf <= 1'b1;
      else if (io_rd)         rx_ovf <= 1'b0;
      if (tx_drop)            tx_ovf <= 1'b1;
      else if (io_rd)         tx_ovf <= 1'b0;
    end
  end
`else
  assign rx_ovf = 1'b0;
  assign tx_ovf = 1'b0;
  logic unused_tx_drop;
  assign unused_tx_drop = tx_drop;
`endif

  // Status byte assembled from registered state; upper bits read as zero
  always_comb begin
    io_status             = 8'h00;
    io_status[ST_RX_NE]   = ~rx_empty;
    io_status[ST_TX_BUSY] = tx_valid;
    io_status[ST_RX_FULL] = rx_full;
    io_status[ST_RX_OVF]  = rx_ovf;
    io_status[ST_TX_OVF]  = tx_ovf;
  end

endmodule

// File: tb/tb_neander_io_ctrl.sv
// Self-checking bench for neander_io_ctrl: vector table plus hand sequences with an RX scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_neander_io_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       io_write;
  logic [7:0] io_out;
  logic       io_rd;
  logic [7:0] io_in;
  logic [7:0] io_status;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic       wr;
    logic [7:0] dout;
    logic       rd;
    logic       trdy;
    logic       rv;
    logic [7:0] rdat;
    logic       e_tv;
    logic [7:0] e_td;
    logic [7:0] e_in;
    logic [7:0] e_st;
    logic       e_rr;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  neander_io_ctrl #(.RX_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .io_write  (io_write),
    .io_out    (io_out),
    .io_rd     (io_rd),
    .io_in     (io_in),
    .io_status (io_status),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // Overflow status bits only exist when the feature is compiled in
  function automatic logic [7:0] ovf(input logic [7:0] bits);
`ifdef NEANDER_IO_OVF_EN
    return bits;
`else
    return 8'h00 & bits;
`endif
  endfunction

  // One clock of stimulus; the scoreboard checks io_in on every read and tracks accepted pushes
  task automatic cycle(input logic wr, input logic [7:0] dout, input logic rd,
                       input logic trdy, input logic rv, input logic [7:0] rdat);
    logic       acc;
    logic [7:0] exp_head;
    io_write = wr;
    io_out   = dout;
    io_rd    = rd;
    tx_ready = trdy;
    rx_valid = rv;
    rx_data  = rdat;
    #1;
    if (rd) begin
      exp_head = 8'h00;
      if (sb_q.size() > 0) exp_head = sb_q[0];
      check("io_in_on_read", io_in, exp_head);
    end
    acc = rv && (sb_q.size() < DEPTH);
    @(posedge clk);
    #1;
    if (rd && sb_q.size() > 0) void'(sb_q.pop_front());
    if (acc) sb_q.push_back(rdat);
    io_write = 1'b0;
    io_rd    = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    io_write = 1'b0;
    io_out   = 8'h00;
    io_rd    = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    //            wr  dout  rd trdy rv rdat    tv  td     in     status                rr
    vecs[0] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 8'h00, 8'h02,                1'b1};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 8'h00, 8'h02,                1'b1};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00,                1'b1};
    vecs[3] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 8'h00, 8'h02,                1'b1};
    vecs[4] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 8'h00, 8'h02 | ovf(8'h10), 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 8'h00, 8'h02 | ovf(8'h10), 1'b1};
    vecs[6] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 8'h00, 8'h02 | ovf(8'h10), 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, ovf(8'h10),         1'b1};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00,                1'b1};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 8'h00, 8'hA1, 8'h01,                1'b1};

    // Reset state while reset is held
    repeat (2) @(posedge clk);
    #1;
    check("rst_status", io_status, 8'h00);
    check("rst_io_in", io_in, 8'h00);
    check("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("rst_tx_data", tx_data, 8'h00);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven TX path and first RX push
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].wr, vecs[i].dout, vecs[i].rd, vecs[i].trdy, vecs[i].rv, vecs[i].rdat);
      check($sformatf("vec%0d_tx_valid", i), {7'b0, tx_valid}, {7'b0, vecs[i].e_tv});
      if (vecs[i].e_tv) check($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].e_td);
      check($sformatf("vec%0d_io_in", i), io_in, vecs[i].e_in);
      check($sformatf("vec%0d_status", i), io_status, vecs[i].e_st);
      check($sformatf("vec%0d_rx_ready", i), {7'b0, rx_ready}, {7'b0, vecs[i].e_rr});
    end

    // Fill the FIFO, offer one more, then drain in order
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hB2);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC3);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hD4);
    check("full_status", io_status, 8'h05);
    check("full_rx_ready", {7'b0, rx_ready}, 8'h00);
    check("full_io_in", io_in, 8'hA1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hE5);
    check("rx_ovf_status", io_status, 8'h05 | ovf(8'h08));
    check("rx_ovf_rx_ready", {7'b0, rx_ready}, 8'h00);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    check("first_pop_status", io_status, 8'h01);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    check("drained_status", io_status, 8'h00);
    check("drained_io_in", io_in, 8'h00);

    // Push and pop in the same cycle with two entries held
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h20);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77);
    check("pushpop_status", io_status, 8'h01);
    check("pushpop_io_in", io_in, 8'h20);
    check("pushpop_rx_ready", {7'b0, rx_ready}, 8'h01);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    check("pushpop_two_left", io_status, 8'h01);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    check("pushpop_empty", io_status, 8'h00);

    // Pop while full with an offer pending: nothing pushed, overflow set beats the read clear
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC0 + 8'(i));
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hEE);
    check("fullpop_status", io_status, 8'h01 | ovf(8'h08));
    check("fullpop_rx_ready", {7'b0, rx_ready}, 8'h01);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    check("fullpop_drained", io_status, 8'h00);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    check("empty_pop_io_in", io_in, 8'h00);

    // Asynchronous reset with a held TX byte and a queued RX byte
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55);
    check("pre_rst_tx_data", tx_data, 8'h99);
    check("pre_rst_status", io_status, 8'h03);
    #2;
    reset = 1'b1;
    #1;
    sb_q.delete();
    check("arst_tx_valid", {7'b0, tx_valid}, 8'h00);
    check("arst_tx_data", tx_data, 8'h00);
    check("arst_status", io_status, 8'h00);
    check("arst_io_in", io_in, 8'h00);
    check("arst_rx_ready", {7'b0, rx_ready}, 8'h01);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
